// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the E-stage datapath and the
// multiply/divide unit.
interface mult_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output A, B, MDOp, Start, Flush,
    input  Busy, HI, LO, Out
  );

  modport slave (
    input  A, B, MDOp, Start, Flush,
    output Busy, HI, LO, Out
  );
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO,
// single-cycle MTHI/MTLO, combinational MFHI/MFLO.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  mult_div_unit_if.slave  md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_n_s;
  logic [CW-1:0] cnt_r, cnt_n_s;
  logic [31:0]   phi_r, plo_r, phi_n_s, plo_n_s;
  logic [31:0]   hi_r, lo_r, hi_n_s, lo_n_s;
  logic          wr_r, wr_n_s;

  logic [63:0]   smul_s, umul_s;
  logic [31:0]   a_mag_s, b_mag_s, div_b_s, q_mag_s, r_mag_s, sq_s, sr_s;
  logic [31:0]   udiv_b_s, uq_s, ur_s;
  logic          b_zero_s, start_ok_s;

  // Result datapath; a zero divisor is swapped for 1 so no X ever reaches the pending regs.
  always_comb begin
    smul_s   = 64'($signed(md.A)) * 64'($signed(md.B));
    umul_s   = {32'd0, md.A} * {32'd0, md.B};
    b_zero_s = (md.B == 32'd0);
    a_mag_s  = md.A[31] ? (32'd0 - md.A) : md.A;
    b_mag_s  = md.B[31] ? (32'd0 - md.B) : md.B;
    div_b_s  = b_zero_s ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / div_b_s;
    r_mag_s  = a_mag_s % div_b_s;
    // Magnitude form makes 0x80000000 / -1 wrap to 0x80000000 with no special case.
    sq_s     = (md.A[31] ^ md.B[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    sr_s     = md.A[31] ? (32'd0 - r_mag_s) : r_mag_s;
    udiv_b_s = b_zero_s ? 32'd1 : md.B;
    uq_s     = md.A / udiv_b_s;
    ur_s     = md.A % udiv_b_s;
    start_ok_s = md.Start && !md.Flush &&
                 (md.MDOp >= 4'd1) && (md.MDOp <= 4'd4);
  end

  // Next-state and next-register logic for the IDLE/RUN controller.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    phi_n_s   = phi_r;
    plo_n_s   = plo_r;
    wr_n_s    = wr_r;
    hi_n_s    = hi_r;
    lo_n_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_n_s = RUN;
          case (md.MDOp)
            4'd1: begin
              {phi_n_s, plo_n_s} = smul_s;
              cnt_n_s = CW'(MULT_CYCLES);
              wr_n_s  = 1'b1;
            end
            4'd2: begin
              {phi_n_s, plo_n_s} = umul_s;
              cnt_n_s = CW'(MULT_CYCLES);
              wr_n_s  = 1'b1;
            end
            4'd3: begin
              {phi_n_s, plo_n_s} = {sr_s, sq_s};
              cnt_n_s = CW'(DIV_CYCLES);
              wr_n_s  = !b_zero_s;
            end
            4'd4: begin
              {phi_n_s, plo_n_s} = {ur_s, uq_s};
              cnt_n_s = CW'(DIV_CYCLES);
              wr_n_s  = !b_zero_s;
            end
            default: begin
              state_n_s = IDLE;
            end
          endcase
        end else if (!md.Flush && (md.MDOp == 4'd5)) begin
          hi_n_s = md.A;
        end else if (!md.Flush && (md.MDOp == 4'd6)) begin
          lo_n_s = md.A;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          // Divide-by-zero leaves HI/LO untouched but still spends the full latency.
          if (wr_r) begin
            hi_n_s = phi_r;
            lo_n_s = plo_r;
          end else begin
            hi_n_s = hi_r;
          end
          cnt_n_s   = '0;
          wr_n_s    = 1'b0;
          state_n_s = IDLE;
        end else begin
          cnt_n_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = '0;
        wr_n_s    = 1'b0;
      end
    endcase
  end

  // State and architectural registers; reset also discards any pending result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      phi_r   <= 32'd0;
      plo_r   <= 32'd0;
      wr_r    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      phi_r   <= phi_n_s;
      plo_r   <= plo_n_s;
      wr_r    <= wr_n_s;
      hi_r    <= hi_n_s;
      lo_r    <= lo_n_s;
    end
  end

  assign md.Busy = (state_r == RUN);
  assign md.HI   = hi_r;
  assign md.LO   = lo_r;

  // MFHI/MFLO read port.
  always_comb begin
    case (md.MDOp)
      4'd7:    md.Out = hi_r;
      4'd8:    md.Out = lo_r;
      default: md.Out = 32'd0;
    endcase
  end
endmodule
